// File: rtl/pwm_deadtime_gen_pkg.sv
// pwm_pkg: shared state encoding, default timing constants and duty clamp
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

    localparam int DEF_PERIOD     = 2000;
    localparam int DEF_DEAD       = 10;
    localparam int DEF_SWITCH_CYC = 200;
    localparam int DEF_MIN_PULSE  = 20;

    function automatic logic [31:0] clamp(input logic [31:0] set, input logic [31:0] period);
        return (set > period) ? period : set;
    endfunction

endpackage

// File: rtl/pwm_deadtime_gen_deadtime_insert.sv
// deadtime_insert: splits a raw PWM level into complementary gates with DEAD idle cycles after every edge
module deadtime_insert
    import pwm_pkg::*;
#(
    parameter int DEAD = DEF_DEAD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act,
    input  logic raw,
    output logic pwm_h,
    output logic pwm_l
);

    localparam int DW = $clog2(DEAD + 2);

    logic          raw_q;
    logic [DW-1:0] dt_cnt;
    logic [DW-1:0] cur;
    logic          ok;

    assign cur = (raw != raw_q) ? '0 : dt_cnt;
    assign ok  = cur >= DW'(DEAD);

    // Track cycles since the last raw edge; gates stay off until that reaches DEAD
    always_ff @(posedge clk) begin
        if (!rst_n || !act) begin
            raw_q  <= 1'b0;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
        end else begin
            raw_q  <= raw;
            dt_cnt <= ok ? DW'(DEAD) : cur + DW'(1);
            pwm_h  <= raw & ok;
            pwm_l  <= ~raw & ok;
        end
    end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: one-phase dead-timed PWM with safe direction reversal; PWM_MIN_PULSE_EN snaps tiny/near-full duties
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int CNT_W      = 16,
    parameter int DEAD       = DEF_DEAD,
    parameter int SWITCH_CYC = DEF_SWITCH_CYC,
    parameter int MIN_PULSE  = DEF_MIN_PULSE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] set,
    input  logic        dir_in,
    output logic        pwm_h,
    output logic        pwm_l,
    output logic        dir_q,
    output logic        period_tick,
    output logic        busy_switch
);

`ifdef PWM_MIN_PULSE_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] sw_cnt;
    logic [31:0]      sat;
    logic [31:0]      duty_eff;
    logic             last;
    logic             rev;
    logic             act;

    assign sat      = clamp(set, 32'(PERIOD));
    assign duty_eff = (MIN_EN && sat != '0 && sat < 32'(MIN_PULSE)) ? '0 :
                      (MIN_EN && sat > 32'(PERIOD - MIN_PULSE) && sat < 32'(PERIOD)) ? 32'(PERIOD) : sat;

    assign last        = cnt == CNT_W'(PERIOD - 1);
    assign rev         = dir_in != dir_q;
    assign act         = en && state == RUN && !(last && rev);
    assign period_tick = state == RUN && last;
    assign busy_switch = state == SWITCH;

    // Sequencing: idle tracking, period counting with wrap-only duty reload, reversal all-off interval
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            duty_q <= '0;
            sw_cnt <= '0;
            dir_q  <= 1'b0;
        end else if (!en) begin
            state  <= IDLE;
            cnt    <= '0;
            sw_cnt <= '0;
            dir_q  <= dir_in;
        end else begin
            case (state)
                IDLE: begin
                    state  <= RUN;
                    cnt    <= '0;
                    duty_q <= CNT_W'(duty_eff);
                    dir_q  <= dir_in;
                end
                RUN: begin
                    cnt <= last ? '0 : cnt + CNT_W'(1);
                    if (last && !rev) duty_q <= CNT_W'(duty_eff);
                    if (last && rev) begin
                        state  <= SWITCH;
                        sw_cnt <= '0;
                    end
                end
                SWITCH: begin
                    if (sw_cnt == CNT_W'(SWITCH_CYC - 1)) begin
                        state  <= RUN;
                        sw_cnt <= '0;
                        dir_q  <= dir_in;
                        duty_q <= CNT_W'(duty_eff);
                    end else begin
                        sw_cnt <= sw_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    deadtime_insert #(.DEAD(DEAD)) u_dt (
        .clk   (clk),
        .rst_n (rst_n),
        .act   (act),
        .raw   (act && cnt < duty_q),
        .pwm_h (pwm_h),
        .pwm_l (pwm_l)
    );

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: directed table of duty vectors plus hand sequences for start-up, reload timing, reversal, en drop and reset
module tb_pwm_deadtime_gen;

    localparam int PERIOD     = 2000;
    localparam int DEAD       = 10;
    localparam int SWITCH_CYC = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] set = '0;
    logic        dir_in = 1'b0;
    logic        pwm_h, pwm_l, dir_q, period_tick, busy_switch;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] set;
        int          hi;
        int          lo;
    } vec_t;

    vec_t vt[13];

    always #5 clk = ~clk;

    pwm_deadtime_gen #(
        .PERIOD(PERIOD), .CNT_W(16), .DEAD(DEAD), .SWITCH_CYC(SWITCH_CYC), .MIN_PULSE(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .set(set), .dir_in(dir_in),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .dir_q(dir_q),
        .period_tick(period_tick), .busy_switch(busy_switch)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 3 * PERIOD);
        check("tick_seen", period_tick, 1);
    endtask

    // Called at the tick sample; skips cnt=0 then samples gates for raw of cnt 0..PERIOD-1
    task automatic measure(output int hi, output int lo, output int ov, output int tk);
        hi = 0; lo = 0; ov = 0; tk = 0;
        @(negedge clk);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            hi += int'(pwm_h);
            lo += int'(pwm_l);
            ov += int'(pwm_h & pwm_l);
            tk += int'(period_tick);
        end
    endtask

    initial begin
        int hi, lo, ov, tk, idx, fh, fl, n, g;

        vt[0]  = '{32'd500,         490,  1490};
        vt[1]  = '{32'd1500,        1490, 490};
        vt[2]  = '{32'd1000,        990,  990};
`ifdef PWM_MIN_PULSE_EN
        vt[3]  = '{32'd11,          0,    2000};
        vt[4]  = '{32'd10,          0,    2000};
`else
        vt[3]  = '{32'd11,          1,    1979};
        vt[4]  = '{32'd10,          0,    1980};
`endif
        vt[5]  = '{32'd0,           0,    2000};
`ifdef PWM_MIN_PULSE_EN
        vt[6]  = '{32'd1990,        1990, 0};
        vt[7]  = '{32'd2000,        2000, 0};
`else
        vt[6]  = '{32'd1990,        1980, 0};
        vt[7]  = '{32'd2000,        1990, 0};
`endif
        vt[8]  = '{32'h0001_0000,   2000, 0};
        vt[9]  = '{32'h0001_0064,   2000, 0};
        vt[10] = '{32'h8000_07D0,   2000, 0};
        vt[11] = '{32'd2001,        2000, 0};
        vt[12] = '{32'd0,           0,    1990};

        // reset holds everything low even with en and dir_in asserted
        en = 1'b1; dir_in = 1'b1; set = 32'd500;
        repeat (3) @(negedge clk);
        check("reset_outputs", {pwm_h, pwm_l, dir_q, period_tick, busy_switch}, 0);

        // start-up: first period timing of gates and tick
        dir_in = 1'b0;
        rst_n = 1'b1;
        idx = 0; fh = 0; fl = 0; ov = 0;
        do begin
            @(negedge clk);
            idx++;
            if (pwm_h && fh == 0) fh = idx;
            if (pwm_l && fl == 0) fl = idx;
            ov += int'(pwm_h & pwm_l);
        end while (!period_tick && idx < 3 * PERIOD);
        check("start_tick_idx", idx, PERIOD);
        check("start_first_h", fh, DEAD + 2);
        check("start_first_l", fl, 500 + DEAD + 2);
        check("start_overlap", ov, 0);
        check("start_dir_q", dir_q, 0);

        // table: new set loads at the next wrap, then one full period is measured
        for (int i = 0; i < 13; i++) begin
            set = vt[i].set;
            wait_tick();
            measure(hi, lo, ov, tk);
            check($sformatf("vec%0d_hi", i), hi, vt[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vt[i].lo);
            check($sformatf("vec%0d_overlap", i), ov, 0);
            check($sformatf("vec%0d_ticks", i), tk, 1);
        end

        // mid-period set change must not take effect before the wrap
        set = 32'd500;
        wait_tick();
        repeat (701) @(negedge clk);
        set = 32'd1500;
        n = 0; hi = 0;
        while (!period_tick && n < 3 * PERIOD) begin
            @(negedge clk);
            hi += int'(pwm_h);
            n++;
        end
        check("midchg_rest_len", n, 1299);
        check("midchg_rest_hi", hi, 0);
        measure(hi, lo, ov, tk);
        check("midchg_next_hi", hi, 1490);
        check("midchg_next_lo", lo, 490);

        // direction reversal requested mid-period
        set = 32'd1000;
        wait_tick();
        repeat (300) @(negedge clk);
        dir_in = 1'b1;
        wait_tick();
        check("rev_dir_before", dir_q, 0);
        check("rev_busy_before", busy_switch, 0);
        @(negedge clk);
        n = 0; g = 0;
        while (busy_switch && n < 1000) begin
            n++;
            g += int'(pwm_h | pwm_l);
            @(negedge clk);
        end
        check("rev_busy_len", n, SWITCH_CYC);
        check("rev_gates_during", g, 0);
        check("rev_dir_after", dir_q, 1);
        idx = 1; fh = 0;
        while (!period_tick && idx < 3 * PERIOD) begin
            @(negedge clk);
            idx++;
            if (pwm_h && fh == 0) fh = idx;
        end
        check("rev_restart_tick", idx, PERIOD);
        check("rev_restart_first_h", fh, DEAD + 2);

        // reversal reverted mid-interval still completes; en drop then aborts it
        dir_in = 1'b0;
        @(negedge clk);
        dir_in = 1'b1;
        repeat (50) @(negedge clk);
        check("revert_still_busy", busy_switch, 1);
        en = 1'b0;
        dir_in = 1'b1;
        @(negedge clk);
        check("endrop_busy", busy_switch, 0);
        check("endrop_gates", {pwm_h, pwm_l}, 0);
        check("endrop_dir", dir_q, 1);
        dir_in = 1'b0;
        @(negedge clk);
        check("idle_dir_follow", dir_q, 0);

        // reset during RUN
        en = 1'b1; dir_in = 1'b1; set = 32'd500;
        @(negedge clk);
        check("idle_entry_dir", dir_q, 1);
        repeat (600) @(negedge clk);
        check("run_pwm_l", pwm_l, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {pwm_h, pwm_l, dir_q, period_tick, busy_switch}, 0);
        rst_n = 1'b1;
        en = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
